// File: rtl/add_sub_pkg.sv
// Shared types and constants for the digit-serial add/sub unit.
package add_sub_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/add_sub_digit.sv
// Combinational DIGIT-bit add slice shared by every serial step.
module add_sub_digit
  import add_sub_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign sum   = total[DIGIT-1:0];
  assign cout  = total[DIGIT];
  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin_msb.
  assign cmsb  = sum[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtracter, LSB digit first, start/done handshake.
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             m,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic             z
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d, s_q, s_d;
  logic             carry_q, carry_d, c_q, c_d, v_q, v_d, z_q, z_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout, dig_cmsb;

  add_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (x_q[DIGIT-1:0]),
    .b    (y_q[DIGIT-1:0]),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout),
    .cmsb (dig_cmsb)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    carry_d = carry_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;

    case (state_q)
      ST_RUN: begin
        x_d     = x_q >> DIGIT;
        y_d     = y_q >> DIGIT;
        res_d   = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
        carry_d = dig_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          s_d     = res_d;
          c_d     = dig_cout;
          v_d     = dig_cmsb ^ dig_cout;
          z_d     = ~|res_d;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Acceptance from IDLE or DONE (back-to-back); start during RUN is dropped.
    if (start && (state_q != ST_RUN)) begin
      x_d     = x;
      y_d     = (m == MODE_SUB) ? ~y : y;
      carry_d = (m == MODE_SUB);
      cnt_d   = '0;
      state_d = ST_RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign ready = (state_q != ST_RUN);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign s     = s_q;
  assign c     = c_q;
  assign v     = v_q;
  assign z     = z_q;

endmodule
